// File: rtl/mips_instr_encoder_if.sv
// rtl/mips_instr_encoder_if.sv - descriptor stream and instruction-memory write bus of the encoder
// master drives descriptors and acks writes; slave is the encoder.
interface mips_instr_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target,
    output mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target,
    input  mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// rtl/mips_instr_encoder.sv - packs decoded MIPS descriptors into 32-bit words and loads them into instruction memory
// One word per cycle when mem_ack is tied high; a held write blocks new descriptors.
module mips_instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  mips_instr_encoder_if.slave bus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W:0]     word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [2:0] K_RTYPE = 3'd0;
  localparam logic [2:0] K_ADDI  = 3'd1;
  localparam logic [2:0] K_LW    = 3'd2;
  localparam logic [2:0] K_SW    = 3'd3;
  localparam logic [2:0] K_BEQ   = 3'd4;
  localparam logic [2:0] K_J     = 3'd5;
  localparam logic [2:0] K_END   = 3'd6;
  localparam logic [2:0] K_ILL   = 3'd7;

  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

  state_t            state_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [ADDR_W:0]   word_count_q;

  logic              ack;
  logic              at_max;
  logic              ready;
  logic              accept;
  logic              is_write;
  logic [31:0]       mem_wdata_d;

  always_comb begin
    ack      = mem_we_q && bus.mem_ack;
    // The last memory slot ends the session, so nothing may be accepted alongside its ack.
    at_max   = mem_we_q && (mem_addr_q == ADDR_MAX);
    ready    = (state_q == S_RUN) && (!mem_we_q || bus.mem_ack) && !at_max;
    accept   = bus.in_valid && ready;
    is_write = (bus.in_kind < K_END);
  end

  always_comb begin
    mem_wdata_d = '0;
    case (bus.in_kind)
      K_RTYPE: mem_wdata_d = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct};
      K_ADDI:  mem_wdata_d = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm};
      K_LW:    mem_wdata_d = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm};
      K_SW:    mem_wdata_d = {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm};
      K_BEQ:   mem_wdata_d = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm};
      K_J:     mem_wdata_d = {6'h02, bus.in_target};
      default: mem_wdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= ADDR_BASE;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      word_count_q <= '0;
    end else begin
      // Write retirement runs in every state so a write left pending by an illegal kind still lands.
      if (ack) begin
        mem_addr_q   <= mem_addr_q + 1'b1;
        word_count_q <= word_count_q + 1'b1;
        mem_we_q     <= 1'b0;
      end
      if (accept && is_write) begin
        mem_we_q    <= 1'b1;
        mem_wdata_q <= mem_wdata_d;
      end

      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q      <= S_RUN;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            word_count_q <= '0;
            mem_addr_q   <= ADDR_BASE;
            mem_we_q     <= 1'b0;
          end
        end
        S_RUN: begin
          if (ack && at_max) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (accept && bus.in_kind == K_END) begin
            if (!mem_we_q || ack) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_DRAIN;
            end
          end else if (accept && bus.in_kind == K_ILL) begin
            state_q <= S_ERR;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (ack) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign word_count    = word_count_q;

endmodule
